// File: rtl/debug_viewer_pkg.sv
// Shared types and constants for the register-file debug viewer.
// Holds the mode encoding, the unmapped-slot marker and the default slot table.
package dbg_pkg;

  typedef enum logic [1:0] {
    DBG_MANUAL = 2'd0,
    DBG_SCAN   = 2'd1,
    DBG_FREEZE = 2'd2,
    DBG_WATCH  = 2'd3
  } dbg_mode_e;

  localparam logic [31:0] DBG_UNMAPPED = 32'hDEADBEEF;

  // Default board view: $zero, $t0-$t4, $ra.
  localparam int DBG_NUM_SLOTS = 7;
  localparam int DBG_SLOT_MAP [DBG_NUM_SLOTS] = '{0, 8, 9, 10, 11, 12, 31};

endpackage

// File: rtl/debug_viewer_if.sv
// Control inputs, register-file tap and display outputs of the debug viewer.
// master drives mode/select/buttons/regs; slave is the viewer itself.
interface debug_viewer_if
  import dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int SEL_W  = 4
);
  dbg_mode_e                    mode;
  logic [SEL_W-1:0]             sel;
  logic                         snap;
  logic                         clr_chg;
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]            dbg_data;
  logic [SEL_W-1:0]             dbg_slot;
  logic                         dbg_chg;
  logic                         dbg_snapv;

  modport master (
    output mode, sel, snap, clr_chg, regs,
    input  dbg_data, dbg_slot, dbg_chg, dbg_snapv
  );

  modport slave (
    input  mode, sel, snap, clr_chg, regs,
    output dbg_data, dbg_slot, dbg_chg, dbg_snapv
  );
endinterface

// File: rtl/dbg_scan_timer.sv
// Auto-scan prescaler and wrapping slot counter.
// slot is the value the slot register takes at this edge, so a registered consumer shows it with one clk latency.
module dbg_scan_timer #(
  parameter int SCAN_DIV  = 50_000_000,
  parameter int NUM_SLOTS = 7,
  parameter int SEL_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_slot,
  output logic [SEL_W-1:0] slot
);
  localparam int               CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SLOT_LAST   = SEL_W'(NUM_SLOTS - 1);
  localparam logic [SEL_W:0]   NUM_SLOTS_X = (SEL_W + 1)'(NUM_SLOTS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] slot_q, slot_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    slot_d = slot_q;
    if (load) begin
      cnt_d  = '0;
      slot_d = ({1'b0, load_slot} < NUM_SLOTS_X) ? load_slot : '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign slot = slot_d;
endmodule

// File: rtl/debug_viewer.sv
// Clocked debug view of the register file: manual, auto-scan, frozen snapshot and change-watch modes.
// Every output is registered; mode/sel/regs reach dbg_data/dbg_slot one clk later.
module debug_viewer
  import dbg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREGS     = 32,
  parameter int NUM_SLOTS = DBG_NUM_SLOTS,
  parameter int SEL_W     = 4,
  parameter int SLOT_MAP [NUM_SLOTS] = DBG_SLOT_MAP,
  parameter int SCAN_DIV  = 50_000_000
) (
  input logic          clk,
  input logic          rst,
  debug_viewer_if.slave bus
);
  localparam logic [DATA_W-1:0] UNMAP       = DATA_W'(DBG_UNMAPPED);
  localparam logic [SEL_W:0]    NUM_SLOTS_X = (SEL_W + 1)'(NUM_SLOTS);

  function automatic logic mapped(input logic [SEL_W-1:0] s);
    return {1'b0, s} < NUM_SLOTS_X;
  endfunction

  function automatic logic [DATA_W-1:0] resolve(input logic [NREGS-1:0][DATA_W-1:0] r,
                                                input logic [SEL_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = UNMAP;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (s == SEL_W'(i)) v = r[SLOT_MAP[i]];
    return v;
  endfunction

  dbg_mode_e         mode_q;
  logic [SEL_W-1:0]  sel_q;
  logic              snap_q;
  logic [DATA_W-1:0] prev_q;
  logic              chg_q;
  logic              snapv_q;
  logic [DATA_W-1:0] bank_q [NUM_SLOTS];
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  slot_q;

  logic              scan_load;
  logic [SEL_W-1:0]  scan_slot;
  logic [DATA_W-1:0] cur_val, bank_val, data_d;
  logic [SEL_W-1:0]  slot_d;
  logic              snap_rise, chg_set;

  assign scan_load = (bus.mode == DBG_SCAN) && (mode_q != DBG_SCAN);

  dbg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .NUM_SLOTS(NUM_SLOTS),
    .SEL_W    (SEL_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .load     (scan_load),
    .load_slot(bus.sel),
    .slot     (scan_slot)
  );

  always_comb begin
    cur_val  = resolve(bus.regs, bus.sel);
    bank_val = UNMAP;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (bus.sel == SEL_W'(i)) bank_val = bank_q[i];
    snap_rise = bus.snap & ~snap_q;
    // Only a steady selection in steady WATCH can flag; entry and sel moves just re-arm prev.
    chg_set = (bus.mode == DBG_WATCH) && (mode_q == DBG_WATCH) && (bus.sel == sel_q) &&
              mapped(bus.sel) && (cur_val != prev_q);
    slot_d = bus.sel;
    data_d = cur_val;
    case (bus.mode)
      DBG_SCAN: begin
        slot_d = scan_slot;
        data_d = resolve(bus.regs, scan_slot);
      end
      DBG_FREEZE: data_d = snapv_q ? bank_val : '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= DBG_MANUAL;
      sel_q   <= '0;
      snap_q  <= 1'b0;
      prev_q  <= '0;
      chg_q   <= 1'b0;
      snapv_q <= 1'b0;
      data_q  <= '0;
      slot_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) bank_q[i] <= '0;
    end else begin
      mode_q <= bus.mode;
      sel_q  <= bus.sel;
      snap_q <= bus.snap;
      prev_q <= cur_val;
      chg_q  <= chg_set | (chg_q & ~bus.clr_chg);
      data_q <= data_d;
      slot_q <= slot_d;
      if (snap_rise) begin
        snapv_q <= 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) bank_q[i] <= bus.regs[SLOT_MAP[i]];
      end
    end
  end

  assign bus.dbg_data  = data_q;
  assign bus.dbg_slot  = slot_q;
  assign bus.dbg_chg   = chg_q;
  assign bus.dbg_snapv = snapv_q;
endmodule
